mux_pack: RTL and testbench

MUX_PACK -- requirements
Module: mux_pack

---
 rtl/mux_pack.sv | 172 +++++++++++++++++
 tb/tb_mux_pack.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pack.sv
// Three-channel byte-to-word packer: bytes from the selected channel are packed MSB-first into one output word.
// Build option: define MUX_PACK_PARTIAL_FLUSH_EN to emit zero-padded partial words on channel change or idle.
module mux_pack #(
  parameter int unsigned MST_DWIDTH = 32,
  parameter int unsigned SYS_DWIDTH = 8
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic [1:0]            select,
  input  logic [SYS_DWIDTH-1:0] data0_i,
  input  logic [SYS_DWIDTH-1:0] data1_i,
  input  logic [SYS_DWIDTH-1:0] data2_i,
  input  logic                  valid0_i,
  input  logic                  valid1_i,
  input  logic                  valid2_i,
  output logic                  ready_o,
  output logic [MST_DWIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int unsigned NBYTES   = 4;
  localparam int unsigned PACK_W   = MST_DWIDTH - SYS_DWIDTH;
  localparam logic [1:0]  SEL_IDLE = 2'd3;
  localparam logic [1:0]  CNT_LAST = 2'd3;

  logic [1:0]            select_q;
  logic [1:0]            cnt_q, cnt_d;
  // Only the first three bytes are staged; the fourth goes straight to data_o.
  logic [PACK_W-1:0]     pack_q, pack_d;
  logic [MST_DWIDTH-1:0] data_d;
  logic                  valid_d;

  logic                  sel_valid_c;
  logic [SYS_DWIDTH-1:0] sel_data_c;
  logic                  chan_chg_c;
  logic                  sel_idle_c;
  logic                  accept_c;
  logic                  flush_pend_c;

`ifdef MUX_PACK_PARTIAL_FLUSH_EN
  logic                  flush_q, flush_d;
  logic                  out_free_c;
  logic [PACK_W-1:0]     partial_c;

  assign flush_pend_c = flush_q;
  assign out_free_c   = !valid_o || ready_i;

  // Keep the bytes received so far, zero the unfilled lower ones.
  always_comb begin
    partial_c = '0;
    for (int unsigned b = 0; b < NBYTES - 1; b++) begin
      if (2'(b) < cnt_q) begin
        partial_c[(NBYTES-2-b)*SYS_DWIDTH +: SYS_DWIDTH] =
          pack_q[(NBYTES-2-b)*SYS_DWIDTH +: SYS_DWIDTH];
      end
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      flush_q <= 1'b0;
    end else begin
      flush_q <= flush_d;
    end
  end
`else
  assign flush_pend_c = 1'b0;
`endif

  // Selected-channel mux and input handshake.
  always_comb begin
    sel_valid_c = 1'b0;
    sel_data_c  = '0;
    case (select)
      2'd0: begin
        sel_valid_c = valid0_i;
        sel_data_c  = data0_i;
      end
      2'd1: begin
        sel_valid_c = valid1_i;
        sel_data_c  = data1_i;
      end
      2'd2: begin
        sel_valid_c = valid2_i;
        sel_data_c  = data2_i;
      end
      default: begin
        sel_valid_c = 1'b0;
        sel_data_c  = '0;
      end
    endcase

    chan_chg_c = (select != select_q);
    sel_idle_c = (select == SEL_IDLE);
    ready_o    = !sel_idle_c && !chan_chg_c && !flush_pend_c &&
                 !((cnt_q == CNT_LAST) && valid_o && !ready_i);
    accept_c   = ready_o && sel_valid_c;
  end

  // Next-state for counter, staging register and output word.
  always_comb begin
    cnt_d   = cnt_q;
    pack_d  = pack_q;
    data_d  = data_o;
    valid_d = valid_o;
`ifdef MUX_PACK_PARTIAL_FLUSH_EN
    flush_d = flush_q;
`endif

    if (valid_o && ready_i) begin
      valid_d = 1'b0;
    end

    if (accept_c) begin
      if (cnt_q == CNT_LAST) begin
        data_d  = {pack_q, sel_data_c};
        valid_d = 1'b1;
        cnt_d   = 2'd0;
        pack_d  = '0;
      end else begin
        for (int unsigned b = 0; b < NBYTES - 1; b++) begin
          if (cnt_q == 2'(b)) begin
            pack_d[(NBYTES-2-b)*SYS_DWIDTH +: SYS_DWIDTH] = sel_data_c;
          end
        end
        cnt_d = cnt_q + 2'd1;
      end
    end else if (chan_chg_c || sel_idle_c) begin
      cnt_d = 2'd0;
      if (cnt_q != 2'd0) begin
        pack_d = '0;
`ifdef MUX_PACK_PARTIAL_FLUSH_EN
        if (out_free_c) begin
          data_d  = {partial_c, SYS_DWIDTH'(0)};
          valid_d = 1'b1;
        end else begin
          pack_d  = partial_c;
          flush_d = 1'b1;
        end
`endif
      end
    end

`ifdef MUX_PACK_PARTIAL_FLUSH_EN
    // Pending partial word waits for the output register to free up.
    if (flush_q && out_free_c) begin
      data_d  = {pack_q, SYS_DWIDTH'(0)};
      valid_d = 1'b1;
      pack_d  = '0;
      flush_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      select_q <= 2'd0;
      cnt_q    <= 2'd0;
      pack_q   <= '0;
      data_o   <= '0;
      valid_o  <= 1'b0;
    end else begin
      select_q <= select;
      cnt_q    <= cnt_d;
      pack_q   <= pack_d;
      data_o   <= data_d;
      valid_o  <= valid_d;
    end
  end

endmodule

// File: tb/tb_mux_pack.sv
// Self-checking bench for mux_pack: per-cycle vector table with handshake checks plus a word scoreboard.
module tb_mux_pack;

  logic        clk_sys;
  logic        rst;
  logic [1:0]  select;
  logic [7:0]  data0_i, data1_i, data2_i;
  logic        valid0_i, valid1_i, valid2_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  v;      // {valid2, valid1, valid0}
    logic [7:0]  d0, d1, d2;
    logic        rdy;
    logic        exp_ready;
    logic        push;
    logic [31:0] push_word;
    logic        chk;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];

  mux_pack #(.MST_DWIDTH(32), .SYS_DWIDTH(8)) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .select   (select),
    .data0_i  (data0_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .valid0_i (valid0_i),
    .valid1_i (valid1_i),
    .valid2_i (valid2_i),
    .ready_o  (ready_o),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [1:0] sel, input logic [2:0] v,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                              input logic rdy, input logic er,
                              input logic push = 1'b0, input logic [31:0] pw = 32'h0,
                              input logic chk = 1'b0, input logic ev = 1'b0,
                              input logic [31:0] ed = 32'h0);
    vec_t r;
    r.sel = sel; r.v = v; r.d0 = d0; r.d1 = d1; r.d2 = d2;
    r.rdy = rdy; r.exp_ready = er; r.push = push; r.push_word = pw;
    r.chk = chk; r.exp_valid = ev; r.exp_data = ed;
    tbl.push_back(r);
  endfunction

  // Drive one vector just after the edge, check combinational/held outputs mid-cycle.
  task automatic apply(input vec_t r, input int idx);
    @(posedge clk_sys);
    #1;
    select   = r.sel;
    valid0_i = r.v[0]; valid1_i = r.v[1]; valid2_i = r.v[2];
    data0_i  = r.d0;   data1_i  = r.d1;   data2_i  = r.d2;
    ready_i  = r.rdy;
    if (r.push) exp_q.push_back(r.push_word);
    @(negedge clk_sys);
    check($sformatf("ready_o[%0d]", idx), 32'(ready_o), 32'(r.exp_ready));
    if (r.chk) begin
      check($sformatf("valid_o[%0d]", idx), 32'(valid_o), 32'(r.exp_valid));
      if (r.exp_valid) check($sformatf("data_o[%0d]", idx), data_o, r.exp_data);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
    tbl.delete();
  endtask

  // Every master-side transfer must match the oldest expected word.
  always @(negedge clk_sys) begin
    if (!rst && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: unexpected word %h, expected none", data_o);
      end else begin
        check("scoreboard", data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    select   = 2'd0;
    data0_i  = '0; data1_i = '0; data2_i = '0;
    valid0_i = 1'b0; valid1_i = 1'b0; valid2_i = 1'b0;
    ready_i  = 1'b0;

    repeat (2) @(negedge clk_sys);
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset data_o", data_o, 32'h0);
    check("reset ready_o", 32'(ready_o), 32'd1);
    rst = 1'b0;

    // Basic four-byte pack on channel 0
    add(2'd0, 3'b001, 8'hDE, 8'h00, 8'h00, 1'b1, 1'b1);
    add(2'd0, 3'b001, 8'hAD, 8'h00, 8'h00, 1'b1, 1'b1);
    add(2'd0, 3'b001, 8'hBE, 8'h00, 8'h00, 1'b1, 1'b1);
    add(2'd0, 3'b001, 8'hEF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
    add(2'd0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF);
    add(2'd0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    // Channel 1 backpressure, then back-to-back reload
    add(2'd1, 3'b010, 8'h00, 8'h11, 8'h00, 1'b0, 1'b0);
    add(2'd1, 3'b010, 8'h00, 8'h11, 8'h00, 1'b0, 1'b1);
    add(2'd1, 3'b010, 8'h00, 8'h12, 8'h00, 1'b0, 1'b1);
    add(2'd1, 3'b010, 8'h00, 8'h13, 8'h00, 1'b0, 1'b1);
    add(2'd1, 3'b010, 8'h00, 8'h14, 8'h00, 1'b0, 1'b1, 1'b1, 32'h11121314);
    add(2'd1, 3'b010, 8'h00, 8'h15, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h11121314);
    add(2'd1, 3'b010, 8'h00, 8'h16, 8'h00, 1'b0, 1'b1);
    add(2'd1, 3'b010, 8'h00, 8'h17, 8'h00, 1'b0, 1'b1);
    add(2'd1, 3'b010, 8'h00, 8'h18, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h11121314);
    add(2'd1, 3'b010, 8'h00, 8'h18, 8'h00, 1'b1, 1'b1, 1'b1, 32'h15161718, 1'b1, 1'b1, 32'h11121314);
    add(2'd1, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h15161718);
    add(2'd1, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    // Channel 2 with noisy valids on the other channels
    add(2'd2, 3'b111, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0);
    add(2'd2, 3'b110, 8'h00, 8'hFF, 8'h01, 1'b1, 1'b1);
    add(2'd2, 3'b101, 8'hFF, 8'h00, 8'h02, 1'b1, 1'b1);
    add(2'd2, 3'b011, 8'hFF, 8'hFF, 8'hAA, 1'b1, 1'b1);
    add(2'd2, 3'b111, 8'hFF, 8'hFF, 8'h03, 1'b1, 1'b1);
    add(2'd2, 3'b100, 8'h00, 8'h00, 8'h04, 1'b1, 1'b1, 1'b1, 32'h01020304);
    add(2'd2, 3'b011, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h01020304);
    add(2'd2, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    // Partial word on channel 0 dropped by a switch to channel 1
    add(2'd0, 3'b001, 8'hAA, 8'h00, 8'h00, 1'b1, 1'b0);
    add(2'd0, 3'b001, 8'hAA, 8'h00, 8'h00, 1'b1, 1'b1);
    add(2'd0, 3'b001, 8'hBB, 8'h00, 8'h00, 1'b1, 1'b1);
    add(2'd1, 3'b010, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0);
    add(2'd1, 3'b010, 8'h00, 8'h01, 8'h00, 1'b1, 1'b1);
    add(2'd1, 3'b010, 8'h00, 8'h02, 8'h00, 1'b1, 1'b1);
    add(2'd1, 3'b010, 8'h00, 8'h03, 8'h00, 1'b1, 1'b1);
    add(2'd1, 3'b010, 8'h00, 8'h04, 8'h00, 1'b1, 1'b1, 1'b1, 32'h01020304);
    add(2'd1, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h01020304);
    add(2'd1, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    // Partial word dropped by going idle (select 3)
    add(2'd1, 3'b010, 8'h00, 8'hC1, 8'h00, 1'b1, 1'b1);
    add(2'd1, 3'b010, 8'h00, 8'hC2, 8'h00, 1'b1, 1'b1);
    add(2'd3, 3'b010, 8'h00, 8'hC3, 8'h00, 1'b1, 1'b0);
    add(2'd3, 3'b010, 8'h00, 8'hC3, 8'h00, 1'b1, 1'b0);
    add(2'd1, 3'b010, 8'h00, 8'hC3, 8'h00, 1'b1, 1'b0);
    add(2'd1, 3'b010, 8'h00, 8'hC3, 8'h00, 1'b1, 1'b1);
    add(2'd1, 3'b010, 8'h00, 8'hC4, 8'h00, 1'b1, 1'b1);
    add(2'd1, 3'b010, 8'h00, 8'hC5, 8'h00, 1'b1, 1'b1);
    add(2'd1, 3'b010, 8'h00, 8'hC6, 8'h00, 1'b1, 1'b1, 1'b1, 32'hC3C4C5C6);
    add(2'd1, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC3C4C5C6);
    add(2'd1, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    // Fill a held word plus three staged bytes ahead of an asynchronous reset
    add(2'd0, 3'b001, 8'h21, 8'h00, 8'h00, 1'b0, 1'b0);
    add(2'd0, 3'b001, 8'h21, 8'h00, 8'h00, 1'b0, 1'b1);
    add(2'd0, 3'b001, 8'h22, 8'h00, 8'h00, 1'b0, 1'b1);
    add(2'd0, 3'b001, 8'h23, 8'h00, 8'h00, 1'b0, 1'b1);
    add(2'd0, 3'b001, 8'h24, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 32'h21222324);
    add(2'd0, 3'b001, 8'h25, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h21222324);
    add(2'd0, 3'b001, 8'h26, 8'h00, 8'h00, 1'b0, 1'b1);
    add(2'd0, 3'b001, 8'h27, 8'h00, 8'h00, 1'b0, 1'b1);
    run_table();

    // Hand sequence: async reset between edges with a word held and cnt at 3
    @(posedge clk_sys);
    #2;
    check("pre-reset valid_o", 32'(valid_o), 32'd1);
    check("pre-reset data_o", data_o, 32'h21222324);
    valid0_i = 1'b0;
    rst = 1'b1;
    #1;
    check("async reset valid_o", 32'(valid_o), 32'd0);
    check("async reset data_o", data_o, 32'h0);
    exp_q.delete();
    @(negedge clk_sys);
    rst = 1'b0;

    add(2'd0, 3'b001, 8'h31, 8'h00, 8'h00, 1'b1, 1'b1);
    add(2'd0, 3'b001, 8'h32, 8'h00, 8'h00, 1'b1, 1'b1);
    add(2'd0, 3'b001, 8'h33, 8'h00, 8'h00, 1'b1, 1'b1);
    add(2'd0, 3'b001, 8'h34, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 32'h31323334);
    add(2'd0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h31323334);
    add(2'd0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    run_table();

    repeat (2) @(negedge clk_sys);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
